// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch path: boot sequencing states
// and the instruction word used when a fetch falls outside the loaded image.
package cpu_pkg;

    typedef enum logic [1:0] {
        LOAD_TABLE = 2'd0,
        LOAD_CODE  = 2'd1,
        RUN        = 2'd2
    } boot_state_e;

    // All-zero word decodes as NOP; callers truncate to their code width.
    localparam logic [31:0] NOP_ENC = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_ram.sv
// Code store: one write port used during boot, one registered read port used
// during RUN. No reset so the array maps onto block RAM.
module instr_mem_ram #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [D-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    input  logic [D-1:0] rd_addr,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem_q [2**D];
    logic [W-1:0] rd_data_q;

    // Read data only moves on an enabled read, so the last word holds otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_boot.sv
// Loadable instruction memory: streams in a branch table then machine code,
// then serves one registered fetch per cycle with an out-of-range guard.
//
// state      | meaning
// LOAD_TABLE | accepting branch-table entries, index tbl_idx_q
// LOAD_CODE  | accepting code words into RAM, address code_idx_q
// RUN        | image loaded, fetches served, load port closed
module instr_mem_boot
    import cpu_pkg::*;
#(
    parameter int D = 12,
    parameter int W = 9,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [D-1:0] load_data,
    input  logic         load_last,
    input  logic         reload,
    output logic         boot_done,
    output logic         load_ovf,
    output logic [D:0]   prog_len,
    input  logic         fetch_en,
    input  logic [D-1:0] prog_ctr,
    output logic [W-1:0] mach_code,
    output logic         fetch_valid,
    output logic         fetch_oob,
    output logic [D-1:0] branch_table [B]
);

    localparam int TW = (B > 1) ? $clog2(B) : 1;
    localparam logic [W-1:0] NOP_WORD = W'(NOP_ENC);

    boot_state_e  state_q, state_d;
    logic [TW-1:0] tbl_idx_q, tbl_idx_d;
    logic [D-1:0]  code_idx_q, code_idx_d;
    logic [D:0]    prog_len_q, prog_len_d;
    logic          ovf_q, ovf_d;
    logic [D-1:0]  table_q [B];
    logic [D-1:0]  table_d [B];

    logic          fetch_valid_q;
    logic          oob_q;
    logic          have_data_q;

    logic          xfer;
    logic          ram_we;
    logic          fetch_go;
    logic          in_range;
    logic [W-1:0]  ram_rdata;

    assign load_ready = (state_q != RUN);
    assign xfer       = load_valid & load_ready;

    always_comb begin
        state_d    = state_q;
        tbl_idx_d  = tbl_idx_q;
        code_idx_d = code_idx_q;
        prog_len_d = prog_len_q;
        ovf_d      = ovf_q;
        table_d    = table_q;
        ram_we     = 1'b0;

        // Reload from any state discards the whole image, partial or complete.
        if (reload) begin
            state_d    = LOAD_TABLE;
            tbl_idx_d  = '0;
            code_idx_d = '0;
            prog_len_d = '0;
            ovf_d      = 1'b0;
            for (int k = 0; k < B; k++) begin
                table_d[k] = '0;
            end
        end else begin
            case (state_q)
                LOAD_TABLE: begin
                    if (xfer) begin
                        for (int k = 0; k < B; k++) begin
                            if (k == int'(tbl_idx_q)) begin
                                table_d[k] = load_data;
                            end else if (load_last && (k > int'(tbl_idx_q))) begin
                                table_d[k] = '0;
                            end
                        end
                        if (load_last) begin
                            prog_len_d = '0;
                            state_d    = RUN;
                        end else if (int'(tbl_idx_q) == B - 1) begin
                            tbl_idx_d = '0;
                            state_d   = LOAD_CODE;
                        end else begin
                            tbl_idx_d = tbl_idx_q + 1'b1;
                        end
                    end
                end
                LOAD_CODE: begin
                    if (xfer) begin
                        ram_we     = 1'b1;
                        prog_len_d = (D+1)'(code_idx_q) + 1'b1;
                        if (load_last) begin
                            state_d = RUN;
                        end else if (&code_idx_q) begin
                            ovf_d   = 1'b1;
                            state_d = RUN;
                        end else begin
                            code_idx_d = code_idx_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = LOAD_TABLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_TABLE;
            tbl_idx_q  <= '0;
            code_idx_q <= '0;
            prog_len_q <= '0;
            ovf_q      <= 1'b0;
            for (int k = 0; k < B; k++) begin
                table_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tbl_idx_q  <= tbl_idx_d;
            code_idx_q <= code_idx_d;
            prog_len_q <= prog_len_d;
            ovf_q      <= ovf_d;
            table_q    <= table_d;
        end
    end

    // A reload in the same cycle cancels the fetch.
    assign fetch_go = fetch_en && (state_q == RUN) && !reload;
    assign in_range = ({1'b0, prog_ctr} < prog_len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            oob_q         <= 1'b0;
            have_data_q   <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_go;
            if (fetch_go) begin
                oob_q       <= !in_range;
                have_data_q <= have_data_q | in_range;
            end
        end
    end

    instr_mem_ram #(
        .D (D),
        .W (W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (code_idx_q),
        .wr_data (load_data[W-1:0]),
        .rd_en   (fetch_go & in_range),
        .rd_addr (prog_ctr),
        .rd_data (ram_rdata)
    );

    // RAM output is unreset; mask it until an in-range word has been read.
    assign mach_code    = (have_data_q && !oob_q) ? ram_rdata : NOP_WORD;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_oob    = fetch_valid_q & oob_q;
    assign boot_done    = (state_q == RUN);
    assign load_ovf     = ovf_q;
    assign prog_len     = prog_len_q;
    assign branch_table = table_q;

endmodule

// File: tb/tb_instr_mem_boot.sv
// Scoreboard bench for instr_mem_boot: random image loads and fetches against
// an image-level reference model.
module tb_instr_mem_boot;

    localparam int D     = 4;
    localparam int W     = 4;
    localparam int B     = 2;
    localparam int DEPTH = 1 << D;

    logic         clk;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [D-1:0] load_data;
    logic         load_last;
    logic         reload;
    logic         boot_done;
    logic         load_ovf;
    logic [D:0]   prog_len;
    logic         fetch_en;
    logic [D-1:0] prog_ctr;
    logic [W-1:0] mach_code;
    logic         fetch_valid;
    logic         fetch_oob;
    logic [D-1:0] branch_table [B];

    instr_mem_boot #(.D(D), .W(W), .B(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .reload       (reload),
        .boot_done    (boot_done),
        .load_ovf     (load_ovf),
        .prog_len     (prog_len),
        .fetch_en     (fetch_en),
        .prog_ctr     (prog_ctr),
        .mach_code    (mach_code),
        .fetch_valid  (fetch_valid),
        .fetch_oob    (fetch_oob),
        .branch_table (branch_table)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the loaded image.
    int           m_tbl [B];
    int           m_mem [DEPTH];
    int           m_len;
    int           m_ovf;

    logic [W:0]   exp_q [$];
    logic [W:0]   mon_e;
    int           last_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_exp = 0;
        end else if (fetch_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: fetch_valid=1 with none outstanding, mach_code=%0d (t=%0t)",
                         mach_code, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("fetch_code", int'(mach_code), int'(mon_e[W-1:0]));
                check("fetch_oob", int'(fetch_oob), int'(mon_e[W]));
                last_exp = int'(mon_e[W-1:0]);
            end
        end else begin
            check("hold_code", int'(mach_code), last_exp);
            check("idle_oob", int'(fetch_oob), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < B; k++) m_tbl[k] = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_len = 0;
        m_ovf = 0;
    endtask

    // Expected image contents from the stream as a whole: the first B words are
    // the table, the rest code, capped at DEPTH words.
    task automatic model_load(input logic [D-1:0] img[$], input bit use_last);
        int n;
        int ncode;
        model_clear();
        n = img.size();
        for (int k = 0; k < B && k < n; k++) m_tbl[k] = int'(img[k]);
        ncode = (n > B) ? n - B : 0;
        if (ncode > DEPTH) ncode = DEPTH;
        for (int i = 0; i < ncode; i++) m_mem[i] = int'(img[B+i]) % (1 << W);
        m_len = ncode;
        m_ovf = (!use_last && ncode == DEPTH) ? 1 : 0;
    endtask

    task automatic stream_image(input logic [D-1:0] img[$], input bit use_last);
        for (int i = 0; i < img.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                load_valid = 1'b0;
                load_data  = D'($urandom);
                load_last  = 1'($urandom);
                step();
            end
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = use_last && (i == img.size() - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_image(input string tag);
        for (int k = 0; k < B; k++) check({tag, "_table"}, int'(branch_table[k]), m_tbl[k]);
        check({tag, "_prog_len"}, int'(prog_len), m_len);
        check({tag, "_load_ovf"}, int'(load_ovf), m_ovf);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_boot_done"}, int'(boot_done), 1);
        check({tag, "_load_ready"}, int'(load_ready), 0);
        check_image(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_load_ready"}, int'(load_ready), 1);
        check({tag, "_boot_done"}, int'(boot_done), 0);
        check({tag, "_load_ovf"}, int'(load_ovf), 0);
        check({tag, "_prog_len"}, int'(prog_len), 0);
        check({tag, "_mach_code"}, int'(mach_code), 0);
        check({tag, "_fetch_valid"}, int'(fetch_valid), 0);
        check({tag, "_fetch_oob"}, int'(fetch_oob), 0);
        for (int k = 0; k < B; k++) check({tag, "_table"}, int'(branch_table[k]), 0);
    endtask

    task automatic issue_fetch(input int pc);
        logic [W:0] v;
        v[W]     = (pc >= m_len);
        v[W-1:0] = (pc < m_len) ? W'(m_mem[pc]) : '0;
        exp_q.push_back(v);
        fetch_en = 1'b1;
        prog_ctr = D'(pc);
        step();
        fetch_en = 1'b0;
    endtask

    task automatic random_fetches(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                fetch_en = 1'b0;
                prog_ctr = D'($urandom);
                step();
            end
            issue_fetch(int'($urandom_range(0, DEPTH - 1)));
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        model_clear();
        check("reload_boot_done", int'(boot_done), 0);
        check("reload_load_ready", int'(load_ready), 1);
        check_image("reload");
    endtask

    logic [D-1:0] img [$];
    int           ncode;

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        reload     = 1'b0;
        fetch_en   = 1'b0;
        prog_ctr   = '0;
        model_clear();
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fetches before boot completes must be ignored.
        repeat (3) begin
            fetch_en = 1'b1;
            prog_ctr = D'($urandom);
            step();
        end
        fetch_en = 1'b0;
        check("preboot_boot_done", int'(boot_done), 0);

        // Directed image: table {5,9}, code {0xF,0x1,0x0}.
        img = '{4'd5, 4'd9, 4'hF, 4'h1, 4'h0};
        model_load(img, 1'b1);
        stream_image(img, 1'b1);
        check_run("img1");
        issue_fetch(0);
        issue_fetch(1);
        issue_fetch(2);
        issue_fetch(3);
        step();

        // Reload wins over a simultaneous fetch.
        fetch_en = 1'b1;
        prog_ctr = '0;
        do_reload();
        fetch_en = 1'b0;
        step();

        // Overflow: full code space with no terminating word.
        img.delete();
        for (int i = 0; i < B + DEPTH; i++) img.push_back(D'($urandom));
        model_load(img, 1'b0);
        stream_image(img, 1'b0);
        check_run("ovf");
        load_valid = 1'b1;
        load_data  = D'($urandom);
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_run("ovf_closed");
        issue_fetch(DEPTH - 1);
        random_fetches(10);
        step();

        // Image terminated on the first table entry: no code at all.
        do_reload();
        img = '{4'd7};
        model_load(img, 1'b1);
        stream_image(img, 1'b1);
        check_run("short");
        random_fetches(6);
        issue_fetch(0);
        step();

        // Random images terminated by load_last.
        repeat (6) begin
            do_reload();
            img.delete();
            ncode = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < B + ncode; i++) img.push_back(D'($urandom));
            model_load(img, 1'b1);
            stream_image(img, 1'b1);
            check_run("rand");
            random_fetches(20);
            step();
        end

        // Async reset in the middle of code loading.
        do_reload();
        img.delete();
        for (int i = 0; i < B + 3; i++) img.push_back(D'($urandom));
        stream_image(img, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_vals("async_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();

        img.delete();
        for (int i = 0; i < B + 5; i++) img.push_back(D'($urandom));
        model_load(img, 1'b1);
        stream_image(img, 1'b1);
        check_run("after_rst");
        random_fetches(12);
        step();
        step();

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
